// File: rtl/addsub_acc_stage_pkg.sv
// Shared state encoding for the add/sub accumulate stage.
package addsub_acc_stage_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StAccum = ST_ACCUM,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/acc_add_flags.sv
// Combinational WIDTH-bit add with unsigned carry-out and signed overflow.
// Vectors are [0:WIDTH-1], so bit 0 is the MSB.
module acc_add_flags #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [0:WIDTH-1] a_i,
    input  logic [0:WIDTH-1] b_i,
    output logic [0:WIDTH-1] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [0:WIDTH] full;

    always_comb begin
        full    = {1'b0, a_i} + {1'b0, b_i};
        sum_o   = full[1:WIDTH];
        carry_o = full[0];
        ovf_o   = (a_i[0] == b_i[0]) && (full[1] != a_i[0]);
    end

endmodule

// File: rtl/addsub_acc_stage.sv
// Streaming reduction stage: sums BURST_LEN add/sub results per output beat and
// reports sticky carry, signed overflow and the number of subtract-op results.
module addsub_acc_stage
    import addsub_acc_stage_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [0:WIDTH-1] in_total_i,
    input  logic             in_carry_i,
    input  logic             in_op_i,
    input  logic             acc_clear_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [0:WIDTH-1] out_sum_o,
    output logic             out_carry_o,
    output logic             out_ovf_o,
    output logic [CNT_W-1:0] out_nsub_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN);

    state_e           state_q;
    logic [0:WIDTH-1] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] nsub_q;
    logic             carry_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [0:WIDTH-1] sum_d;
    logic             carry_d;
    logic             ovf_d;
    logic [CNT_W-1:0] count_d;
    logic             beat;

    // acc_q is zero whenever the FSM sits in StIdle, so the first beat loads in_total directly.
    acc_add_flags #(
        .WIDTH(WIDTH)
    ) u_add (
        .a_i    (acc_q),
        .b_i    (in_total_i),
        .sum_o  (sum_d),
        .carry_o(carry_d),
        .ovf_o  (ovf_d)
    );

    assign count_d = count_q + CNT_W'(1);
    assign beat    = in_valid_i && in_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            nsub_q      <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    in_ready_q <= 1'b1;
                    if (acc_clear_i) begin
                        state_q <= StIdle;
                        acc_q   <= '0;
                        count_q <= '0;
                        nsub_q  <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else if (beat) begin
                        acc_q   <= sum_d;
                        count_q <= count_d;
                        nsub_q  <= nsub_q + CNT_W'(!in_op_i);
                        carry_q <= carry_q | carry_d | in_carry_i;
                        ovf_q   <= ovf_q | ovf_d;
                        if (count_d == LastCnt) begin
                            state_q     <= StDone;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        acc_q       <= '0;
                        count_q     <= '0;
                        nsub_q      <= '0;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = acc_q;
    assign out_carry_o = carry_q;
    assign out_ovf_o   = ovf_q;
    assign out_nsub_o  = nsub_q;

endmodule

// File: tb/tb_addsub_acc_stage.sv
// Scoreboard bench for addsub_acc_stage: directed bursts push expected beats,
// a monitor pops and compares on every output transfer.
module tb_addsub_acc_stage;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic [2:0]  nsub;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:31] in_total = '0;
    logic        in_carry = 1'b0;
    logic        in_op = 1'b1;
    logic        acc_clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:31] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic [2:0]  out_nsub;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    addsub_acc_stage dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_total_i (in_total),
        .in_carry_i (in_carry),
        .in_op_i    (in_op),
        .acc_clear_i(acc_clear),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_carry_o(out_carry),
        .out_ovf_o  (out_ovf),
        .out_nsub_o (out_nsub)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Called between edges; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [31:0] total, input logic op, input logic cy);
        logic ok;
        int   budget;
        in_total = total;
        in_op    = op;
        in_carry = cy;
        in_valid = 1'b1;
        budget   = 0;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            budget++;
            if (budget > 50) begin
                chk("send_beat timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_carry = 1'b0;
    endtask

    task automatic wait_ready();
        int budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 50) chk("wait_ready timeout", 32'd0, 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                a = '{sum: out_sum, carry: out_carry, ovf: out_ovf, nsub: out_nsub};
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected beat: got sum=0x%08h, want none", a.sum);
                end else begin
                    e = sb_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL burst: got sum=0x%08h c=%0b v=%0b nsub=%0d, want sum=0x%08h c=%0b v=%0b nsub=%0d",
                                 a.sum, a.carry, a.ovf, a.nsub, e.sum, e.carry, e.ovf, e.nsub);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_sum", out_sum, 32'd0);
        chk("rst flags", {29'd0, out_carry, out_ovf, 1'b0}, 32'd0);
        chk("rst nsub", 32'(out_nsub), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready after rst", 32'(in_ready), 32'd1);

        // 2: mixed add/sub burst
        sb_q.push_back('{sum: 32'd9354, carry: 1'b1, ovf: 1'b0, nsub: 3'd1});
        send_beat(32'd5229, 1'b1, 1'b0);
        send_beat(-32'sd2377, 1'b0, 1'b0);
        send_beat(32'd5740, 1'b1, 1'b0);
        chk("no early out_valid", 32'(out_valid), 32'd0);
        send_beat(32'd762, 1'b1, 1'b0);
        chk("out_valid latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("done lasts one cycle", 32'(out_valid), 32'd0);

        // 3: signed overflow, then unsigned carry
        sb_q.push_back('{sum: 32'h8000_0000, carry: 1'b0, ovf: 1'b1, nsub: 3'd0});
        send_beat(32'h7FFF_FFFF, 1'b1, 1'b0);
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd0, 1'b1, 1'b0);
        send_beat(32'd0, 1'b1, 1'b0);
        wait_ready();
        sb_q.push_back('{sum: 32'h0, carry: 1'b1, ovf: 1'b0, nsub: 3'd0});
        send_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd0, 1'b1, 1'b0);
        send_beat(32'd0, 1'b1, 1'b0);
        wait_ready();

        // 4: backpressure in DONE with a pending input beat
        out_ready = 1'b0;
        sb_q.push_back('{sum: 32'd100, carry: 1'b1, ovf: 1'b0, nsub: 3'd2});
        sb_q.push_back('{sum: 32'd10, carry: 1'b0, ovf: 1'b0, nsub: 3'd0});
        send_beat(32'd10, 1'b0, 1'b0);
        send_beat(32'd20, 1'b1, 1'b1);
        send_beat(32'd30, 1'b0, 1'b0);
        send_beat(32'd40, 1'b1, 1'b0);
        in_total = 32'd7;
        in_op    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold in_ready", 32'(in_ready), 32'd0);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold out_sum", out_sum, 32'd100);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle in_ready", 32'(in_ready), 32'd1);
        chk("idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd1, 1'b1, 1'b0);
        wait_ready();

        // 5: acc_clear mid-burst drops the in-flight beat
        send_beat(32'd100, 1'b0, 1'b1);
        send_beat(32'd100, 1'b0, 1'b0);
        acc_clear = 1'b1;
        in_valid  = 1'b1;
        in_total  = 32'd50;
        @(posedge clk);
        #1;
        acc_clear = 1'b0;
        in_valid  = 1'b0;
        chk("clear acc", out_sum, 32'd0);
        chk("clear flags", {29'd0, out_carry, out_nsub[1:0]}, 32'd0);
        chk("clear in_ready", 32'(in_ready), 32'd1);
        sb_q.push_back('{sum: 32'd4, carry: 1'b0, ovf: 1'b0, nsub: 3'd0});
        for (int i = 0; i < 4; i++) send_beat(32'd1, 1'b1, 1'b0);
        wait_ready();

        // 6: reset while holding a result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'd3, 1'b1, 1'b0);
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst drop out_valid", 32'(out_valid), 32'd0);
        chk("rst drop out_sum", out_sum, 32'd0);
        chk("rst drop in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        sb_q.push_back('{sum: 32'd8, carry: 1'b0, ovf: 1'b0, nsub: 3'd4});
        for (int i = 0; i < 4; i++) send_beat(32'd2, 1'b0, 1'b0);

        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
